// File: rtl/wbu_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// wbu_pipeline_pkg
//   Shared definitions for the write-back stage: machine CSR addresses,
//   mcause codes, mstatus bit positions and the write-back FSM state type.
// ---------------------------------------------------------------------------
package wbu_pipeline_pkg;

  // Machine CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // mcause codes
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

  // mstatus bit positions
  localparam int MSTATUS_MIE      = 3;
  localparam int MSTATUS_MPIE     = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // Write-back sequencing: normal retire, one-cycle redirect, halted
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_HALT  = 2'd2
  } wbu_state_t;

endpackage

// File: rtl/wbu_pipeline_if.sv
// ---------------------------------------------------------------------------
// wbu_pipeline_if
//   Retiring-beat bus from the LSU stage into the write-back stage.
//   master : LSU side, drives the beat and samples in_ready
//   slave  : WBU side, samples the beat and drives in_ready
// ---------------------------------------------------------------------------
interface wbu_pipeline_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic        in_csr_wen;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_wdata;
  logic        in_ebreak;
  logic        in_ecall;
  logic        in_mret;

  modport master (
    output in_valid, in_pc, in_inst, in_result, in_rd, in_reg_wen,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ebreak, in_ecall, in_mret,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_result, in_rd, in_reg_wen,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ebreak, in_ecall, in_mret,
    output in_ready
  );

endinterface

// File: rtl/wbu_pipeline_csr_file.sv
// ---------------------------------------------------------------------------
// wbu_csr_file
//   Machine CSR storage for the write-back stage: mstatus, mtvec, mepc,
//   mcause, mcycle, minstret, plus the combinational read mux.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   fire            a beat retired this cycle (drives minstret)
//   csr_wen         CSR write, already qualified by fire and op priority
//   csr_addr/wdata  CSR write address / data
//   ecall_act       ecall retiring: capture mepc/mcause
//   mret_act        mret retiring: restore mstatus interrupt enable
//   trap_pc         pc of the retiring beat
//   csr_raddr       read address, csr_rdata combinational read data
//   mtvec, mepc     current values for redirect target selection
// ---------------------------------------------------------------------------
module wbu_csr_file
  import wbu_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] ECALL_CAUSE   = CAUSE_ECALL_M
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        ecall_act,
  input  logic        mret_act,
  input  logic [31:0] trap_pc,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic [31:0] mstatus;
  logic [31:0] mcause;
  logic [31:0] mcycle;
  logic [31:0] minstret;
  logic [31:0] mstatus_mret;

  // mret pops the interrupt-enable stack and pins MPP to machine mode
  always_comb begin
    mstatus_mret = mstatus;
    mstatus_mret[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE] = 1'b1;
    mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Trap/mret updates and CSR writes are mutually exclusive upstream,
  // so the ordering here only matters for readability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus <= RESET_MSTATUS;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      if (mret_act)
        mstatus <= mstatus_mret;
      else if (csr_wen && csr_addr == CSR_MSTATUS)
        mstatus <= csr_wdata;

      if (csr_wen && csr_addr == CSR_MTVEC)
        mtvec <= csr_wdata;

      if (ecall_act) begin
        mepc   <= trap_pc;
        mcause <= ECALL_CAUSE;
      end else begin
        if (csr_wen && csr_addr == CSR_MEPC)
          mepc <= csr_wdata;
        if (csr_wen && csr_addr == CSR_MCAUSE)
          mcause <= csr_wdata;
      end
    end
  end

  // Free-running counters; an explicit write replaces that cycle's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_wen && csr_addr == CSR_MCYCLE)
        mcycle <= csr_wdata;
      else
        mcycle <= mcycle + 32'd1;

      if (csr_wen && csr_addr == CSR_MINSTRET)
        minstret <= csr_wdata;
      else if (fire)
        minstret <= minstret + 32'd1;
    end
  end

  // Plain read of current state; no write bypass, unknown addresses read 0
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:  csr_rdata = mstatus;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MCYCLE:   csr_rdata = mcycle;
      CSR_MINSTRET: csr_rdata = minstret;
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/wbu_pipeline.sv
// ---------------------------------------------------------------------------
// wbu_pipeline
//   Write-back stage. Accepts retiring beats from the LSU, drives the GPR
//   write port, owns the machine CSRs and turns ecall/mret into a one-cycle
//   redirect+flush pulse. ebreak halts the core until reset.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   beat                  retiring-beat bus (slave side)
//   rf_wen/waddr/wdata    GPR write port, combinational from the beat
//   csr_raddr/csr_rdata   CSR read port for the EXU
//   redirect/redirect_pc  one-cycle fetch redirect and flush
//   halt/halt_pc          sticky halt after ebreak and its pc
//   retire/retire_pc      one-cycle pulse per retired instruction
// ---------------------------------------------------------------------------
module wbu_pipeline
  import wbu_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] ECALL_CAUSE   = CAUSE_ECALL_M
) (
  input  logic          clk,
  input  logic          rst,
  wbu_pipeline_if.slave beat,
  output logic          rf_wen,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  input  logic [11:0]   csr_raddr,
  output logic [31:0]   csr_rdata,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic          halt,
  output logic [31:0]   halt_pc,
  output logic          retire,
  output logic [31:0]   retire_pc
);

  wbu_state_t  state;
  logic        fire;
  logic        do_ebreak;
  logic        do_ecall;
  logic        do_mret;
  logic        do_csr;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        unused_inst;

  assign unused_inst = ^beat.in_inst;

  // Nothing is taken while halted or while the older stages are being
  // flushed; a beat presented during reset is not retired either
  assign beat.in_ready = !halt && !redirect;
  assign fire          = beat.in_valid && beat.in_ready && !rst;

  // Only the highest-priority system op in a beat takes effect
  assign do_ebreak = fire && beat.in_ebreak;
  assign do_ecall  = fire && beat.in_ecall && !beat.in_ebreak;
  assign do_mret   = fire && beat.in_mret && !beat.in_ebreak && !beat.in_ecall;
  assign do_csr    = fire && beat.in_csr_wen && !beat.in_ebreak &&
                     !beat.in_ecall && !beat.in_mret;

  assign rf_wen   = fire && beat.in_reg_wen;
  assign rf_waddr = beat.in_rd;
  assign rf_wdata = beat.in_result;

  wbu_csr_file #(
    .RESET_MSTATUS (RESET_MSTATUS),
    .ECALL_CAUSE   (ECALL_CAUSE)
  ) u_csr (
    .clk       (clk),
    .rst       (rst),
    .fire      (fire),
    .csr_wen   (do_csr),
    .csr_addr  (beat.in_csr_addr),
    .csr_wdata (beat.in_csr_wdata),
    .ecall_act (do_ecall),
    .mret_act  (do_mret),
    .trap_pc   (beat.in_pc),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .mtvec     (mtvec),
    .mepc      (mepc)
  );

  // Write-back FSM with registered redirect/halt/retire outputs. The
  // redirect target is taken from mtvec/mepc before this edge updates them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      halt        <= 1'b0;
      halt_pc     <= '0;
      retire      <= 1'b0;
      retire_pc   <= '0;
    end else begin
      retire <= fire;
      if (fire)
        retire_pc <= beat.in_pc;

      case (state)
        ST_RUN: begin
          if (do_ebreak) begin
            state   <= ST_HALT;
            halt    <= 1'b1;
            halt_pc <= beat.in_pc;
          end else if (do_ecall) begin
            state       <= ST_REDIR;
            redirect    <= 1'b1;
            redirect_pc <= mtvec;
          end else if (do_mret) begin
            state       <= ST_REDIR;
            redirect    <= 1'b1;
            redirect_pc <= mepc;
          end
        end
        ST_REDIR: begin
          state    <= ST_RUN;
          redirect <= 1'b0;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state    <= ST_RUN;
          redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_pipeline.sv
// ---------------------------------------------------------------------------
// tb_wbu_pipeline
//   Directed bench for the write-back stage: GPR write, CSR write, ecall,
//   mret, counter wrap/override, ebreak halt and reset during redirect.
// ---------------------------------------------------------------------------
module tb_wbu_pipeline;
  import wbu_pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] halt_pc;
  logic        retire;
  logic [31:0] retire_pc;

  int assert_count = 0;
  int fail_count   = 0;

  wbu_pipeline_if bus ();

  wbu_pipeline dut (
    .clk         (clk),
    .rst         (rst),
    .beat        (bus.slave),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halt_pc     (halt_pc),
    .retire      (retire),
    .retire_pc   (retire_pc)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one beat onto the LSU bus
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [31:0] result,
                               input logic reg_wen, input logic csr_wen,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic ebreak, input logic ecall,
                               input logic mret);
    bus.in_valid     = valid;
    bus.in_pc        = pc;
    bus.in_inst      = 32'h0000_0013;
    bus.in_rd        = rd;
    bus.in_result    = result;
    bus.in_reg_wen   = reg_wen;
    bus.in_csr_wen   = csr_wen;
    bus.in_csr_addr  = addr;
    bus.in_csr_wdata = wdata;
    bus.in_ebreak    = ebreak;
    bus.in_ecall     = ecall;
    bus.in_mret      = mret;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0,
                  1'b0, 1'b0, 1'b0);
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCsr(input string tag, input logic [11:0] addr,
                          input logic [31:0] exp);
    csr_raddr = addr;
    #1;
    checkOutput(tag, csr_rdata, exp);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_in_ready"},    {31'd0, bus.in_ready}, 32'd1);
    checkOutput({pfx, "_rf_wen"},      {31'd0, rf_wen},       32'd0);
    checkOutput({pfx, "_redirect"},    {31'd0, redirect},     32'd0);
    checkOutput({pfx, "_redirect_pc"}, redirect_pc,           32'd0);
    checkOutput({pfx, "_halt"},        {31'd0, halt},         32'd0);
    checkOutput({pfx, "_halt_pc"},     halt_pc,               32'd0);
    checkOutput({pfx, "_retire"},      {31'd0, retire},       32'd0);
    checkOutput({pfx, "_retire_pc"},   retire_pc,             32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    csr_raddr = 12'h0;
    idle();

    // Reset values
    tick();
    tick();
    checkResetOutputs("rst");
    checkCsr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    checkCsr("rst_mcycle", CSR_MCYCLE, 32'h0);
    checkCsr("rst_unknown_csr", 12'h123, 32'h0);
    rst = 1'b0;

    // 1. ALU beat: combinational GPR write, retire one cycle later
    tick();
    applyStimulus(1'b1, 32'h8000_0000, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0,
                  12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t1_rf_wen", {31'd0, rf_wen}, 32'd1);
    checkOutput("t1_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    checkOutput("t1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    checkOutput("t1_retire_before", {31'd0, retire}, 32'd0);
    checkCsr("t1_minstret_before", CSR_MINSTRET, 32'd0);
    tick();
    idle();
    #1;
    checkOutput("t1_retire", {31'd0, retire}, 32'd1);
    checkOutput("t1_retire_pc", retire_pc, 32'h8000_0000);
    checkOutput("t1_rf_wen_idle", {31'd0, rf_wen}, 32'd0);
    checkCsr("t1_minstret_after", CSR_MINSTRET, 32'd1);
    tick();
    checkOutput("t1_retire_drop", {31'd0, retire}, 32'd0);

    // 2. mtvec write then ecall
    applyStimulus(1'b1, 32'h8000_0004, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MTVEC, 32'h8000_0100, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t2_mtvec", CSR_MTVEC, 32'h8000_0100);
    applyStimulus(1'b1, 32'h8000_0040, 5'd0, 32'h0, 1'b0, 1'b0,
                  12'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("t2_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("t2_redirect_pc", redirect_pc, 32'h8000_0100);
    checkOutput("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkCsr("t2_mepc", CSR_MEPC, 32'h8000_0040);
    checkCsr("t2_mcause", CSR_MCAUSE, 32'd11);
    // A beat offered during the redirect cycle is not accepted
    applyStimulus(1'b1, 32'h8000_0044, 5'd7, 32'h1234, 1'b1, 1'b0,
                  12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t2_redir_rf_wen", {31'd0, rf_wen}, 32'd0);
    idle();
    tick();
    checkOutput("t2_redirect_drop", {31'd0, redirect}, 32'd0);
    checkOutput("t2_ready_back", {31'd0, bus.in_ready}, 32'd1);
    checkCsr("t2_minstret", CSR_MINSTRET, 32'd3);

    // 3. mret: MIE takes MPIE, MPIE set, MPP stays M
    applyStimulus(1'b1, 32'h8000_0100, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MSTATUS, 32'h0000_1880, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t3_mstatus_wr", CSR_MSTATUS, 32'h0000_1880);
    applyStimulus(1'b1, 32'h8000_0104, 5'd0, 32'h0, 1'b0, 1'b0,
                  12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("t3_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("t3_redirect_pc", redirect_pc, 32'h8000_0040);
    checkCsr("t3_mstatus_mret", CSR_MSTATUS, 32'h0000_1888);
    tick();
    checkOutput("t3_redirect_drop", {31'd0, redirect}, 32'd0);

    // 6. ecall with csr_wen in the same beat, then reset in the REDIR cycle
    applyStimulus(1'b1, 32'h8000_0200, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MTVEC, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkCsr("t6_mtvec_kept", CSR_MTVEC, 32'h8000_0100);
    checkCsr("t6_mepc", CSR_MEPC, 32'h8000_0200);
    checkCsr("t6_mcause", CSR_MCAUSE, 32'd11);
    checkOutput("t6_redirect", {31'd0, redirect}, 32'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_rst");
    checkCsr("t6_rst_mepc", CSR_MEPC, 32'h0);
    tick();
    rst = 1'b0;

    // 5. mcycle wrap and write override; minstret write wins over its beat
    applyStimulus(1'b1, 32'h8000_0300, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t5_mcycle_pre", CSR_MCYCLE, 32'hFFFF_FFFF);
    tick();
    checkCsr("t5_mcycle_wrap", CSR_MCYCLE, 32'h0);
    applyStimulus(1'b1, 32'h8000_0304, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MCYCLE, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t5_mcycle_wr", CSR_MCYCLE, 32'h10);
    tick();
    checkCsr("t5_mcycle_inc", CSR_MCYCLE, 32'h11);
    checkCsr("t5_minstret_cnt", CSR_MINSTRET, 32'd2);
    applyStimulus(1'b1, 32'h8000_0308, 5'd0, 32'h0, 1'b0, 1'b1,
                  CSR_MINSTRET, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t5_minstret_wr", CSR_MINSTRET, 32'h100);
    applyStimulus(1'b1, 32'h8000_030C, 5'd1, 32'h5, 1'b1, 1'b0,
                  12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkCsr("t5_minstret_inc", CSR_MINSTRET, 32'h101);

    // 4. ebreak with in_valid held high afterwards
    applyStimulus(1'b1, 32'h8000_0080, 5'd3, 32'h1, 1'b1, 1'b0,
                  12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("t4_ebreak_rf_wen", {31'd0, rf_wen}, 32'd1);
    tick();
    checkOutput("t4_halt", {31'd0, halt}, 32'd1);
    checkOutput("t4_halt_pc", halt_pc, 32'h8000_0080);
    checkOutput("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("t4_retire", {31'd0, retire}, 32'd1);
    checkOutput("t4_rf_wen_halted", {31'd0, rf_wen}, 32'd0);
    checkCsr("t4_minstret", CSR_MINSTRET, 32'h102);
    tick();
    tick();
    checkOutput("t4_halt_sticky", {31'd0, halt}, 32'd1);
    checkOutput("t4_retire_drop", {31'd0, retire}, 32'd0);
    checkOutput("t4_redirect", {31'd0, redirect}, 32'd0);
    checkCsr("t4_minstret_frozen", CSR_MINSTRET, 32'h102);
    rst = 1'b1;
    #1;
    checkResetOutputs("t4_rst");
    checkCsr("t4_rst_minstret", CSR_MINSTRET, 32'h0);
    checkCsr("t4_rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    idle();
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
